// File: rtl/multi_debouncer.sv
// Multi-channel button/sensor debouncer: 2-flop synchroniser, stable-time filter,
// debounced level with rise/fall pulses and a one-shot long-press (hold) pulse.
module multi_debouncer #(
    parameter int NUM_CH = 4,
    parameter int DEBOUNCE_CYCLES = 800_000,
    parameter int HOLD_CYCLES = 80_000_000,
    parameter logic [NUM_CH-1:0] INVERT = {NUM_CH{1'b0}},
    parameter int CNT_W = $clog2(((DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES) + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] button,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] hold
);

    localparam bit              HOLD_EN = (HOLD_CYCLES > 0);
    localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC = HOLD_EN ? CNT_W'(HOLD_CYCLES - 1) : '0;

    logic [NUM_CH-1:0] s1;
    logic [NUM_CH-1:0] s2;
    logic [NUM_CH-1:0] hold_done;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] hold_hit;
    logic [CNT_W-1:0]  dcnt [NUM_CH];
    logic [CNT_W-1:0]  hcnt [NUM_CH];

    // A channel whose level is falling on this edge must not also fire hold.
    always_comb begin
        accept   = '0;
        hold_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            accept[i]   = (s2[i] != level[i]) && (dcnt[i] == DEB_TC);
            hold_hit[i] = HOLD_EN && level[i] && !hold_done[i] && !accept[i]
                          && (hcnt[i] == HOLD_TC);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            level     <= '0;
            rise      <= '0;
            fall      <= '0;
            hold      <= '0;
            hold_done <= '0;
            dcnt      <= '{default: '0};
            hcnt      <= '{default: '0};
        end else begin
            s1 <= button ^ INVERT;
            s2 <= s1;
            for (int i = 0; i < NUM_CH; i++) begin
                rise[i] <= accept[i] & s2[i];
                fall[i] <= accept[i] & ~s2[i];
                hold[i] <= hold_hit[i];

                if ((s2[i] == level[i]) || accept[i])
                    dcnt[i] <= '0;
                else
                    dcnt[i] <= dcnt[i] + CNT_W'(1);

                if (accept[i])
                    level[i] <= s2[i];

                if (!HOLD_EN || !level[i] || accept[i]) begin
                    hcnt[i]      <= '0;
                    hold_done[i] <= 1'b0;
                end else if (hold_hit[i]) begin
                    hcnt[i]      <= '0;
                    hold_done[i] <= 1'b1;
                end else if (!hold_done[i]) begin
                    hcnt[i] <= hcnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: 4 channels, debounce 4, hold 10, ch2 active-low.
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] button;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hold;

    int checks   = 0;
    int failures = 0;

    localparam logic [3:0] IDLE = 4'b0100;

    multi_debouncer #(
        .NUM_CH(4),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10),
        .INVERT(4'b0100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button(button),
        .level(level),
        .rise(rise),
        .fall(fall),
        .hold(hold)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        button = IDLE;
        tick(3);
        checks++; if ({level, rise, fall, hold} !== 16'h0) begin failures++;
            $display("FAIL reset_in got=%h exp=0000", {level, rise, fall, hold}); end
        reset = 1'b0;
        tick(4);
        checks++; if ({level, rise, fall, hold} !== 16'h0) begin failures++;
            $display("FAIL reset_after got=%h exp=0000", {level, rise, fall, hold}); end
    endtask

    // ch0 press: level/rise at E5, rise gone at E6; then release: fall at E5.
    task automatic test_clean_press;
        logic [3:0] el, er, ef;
        button = IDLE | 4'b0001;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            el = (k >= 5) ? 4'b0001 : 4'b0000;
            er = (k == 5) ? 4'b0001 : 4'b0000;
            checks++; if (level !== el) begin failures++;
                $display("FAIL press_level k=%0d got=%b exp=%b", k, level, el); end
            checks++; if (rise !== er) begin failures++;
                $display("FAIL press_rise k=%0d got=%b exp=%b", k, rise, er); end
            checks++; if ({fall, hold} !== 8'h0) begin failures++;
                $display("FAIL press_fallhold k=%0d got=%b exp=00000000", k, {fall, hold}); end
        end
        button = IDLE;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            el = (k >= 5) ? 4'b0000 : 4'b0001;
            ef = (k == 5) ? 4'b0001 : 4'b0000;
            checks++; if (level !== el) begin failures++;
                $display("FAIL release_level k=%0d got=%b exp=%b", k, level, el); end
            checks++; if (fall !== ef) begin failures++;
                $display("FAIL release_fall k=%0d got=%b exp=%b", k, fall, ef); end
            checks++; if ({rise, hold} !== 8'h0) begin failures++;
                $display("FAIL release_risehold k=%0d got=%b exp=00000000", k, {rise, hold}); end
        end
    endtask

    // ch1: 10 cycles of 1,0,1,0..., a 3-cycle glitch, then a steady press.
    task automatic test_bounce;
        logic [3:0] el, er;
        for (int k = 0; k < 10; k++) begin
            button = IDLE | ((k % 2 == 0) ? 4'b0010 : 4'b0000);
            tick(1);
            checks++; if ({level, rise, fall} !== 12'h0) begin failures++;
                $display("FAIL bounce k=%0d got=%b exp=0", k, {level, rise, fall}); end
        end
        button = IDLE;
        tick(3);
        button = IDLE | 4'b0010;
        tick(3);
        button = IDLE;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            checks++; if ({level, rise, fall} !== 12'h0) begin failures++;
                $display("FAIL glitch k=%0d got=%b exp=0", k, {level, rise, fall}); end
        end
        button = IDLE | 4'b0010;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            el = (k >= 5) ? 4'b0010 : 4'b0000;
            er = (k == 5) ? 4'b0010 : 4'b0000;
            checks++; if (level !== el) begin failures++;
                $display("FAIL bounce_level k=%0d got=%b exp=%b", k, level, el); end
            checks++; if (rise !== er) begin failures++;
                $display("FAIL bounce_rise k=%0d got=%b exp=%b", k, rise, er); end
        end
        button = IDLE;
        tick(8);
        checks++; if (level !== 4'b0000) begin failures++;
            $display("FAIL bounce_release got=%b exp=0000", level); end
    endtask

    // ch2 is active-low: raw 1 idles at level 0, raw 0 is a press.
    task automatic test_invert;
        logic [3:0] el, er, ef;
        button = 4'b0000;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            el = (k >= 5) ? 4'b0100 : 4'b0000;
            er = (k == 5) ? 4'b0100 : 4'b0000;
            checks++; if (level !== el) begin failures++;
                $display("FAIL inv_press_level k=%0d got=%b exp=%b", k, level, el); end
            checks++; if (rise !== er) begin failures++;
                $display("FAIL inv_press_rise k=%0d got=%b exp=%b", k, rise, er); end
        end
        button = IDLE;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            el = (k >= 5) ? 4'b0000 : 4'b0100;
            ef = (k == 5) ? 4'b0100 : 4'b0000;
            checks++; if (level !== el) begin failures++;
                $display("FAIL inv_rel_level k=%0d got=%b exp=%b", k, level, el); end
            checks++; if (fall !== ef) begin failures++;
                $display("FAIL inv_rel_fall k=%0d got=%b exp=%b", k, fall, ef); end
            checks++; if (hold !== 4'b0000) begin failures++;
                $display("FAIL inv_hold k=%0d got=%b exp=0000", k, hold); end
        end
    endtask

    // ch3 long press twice: rise at E5, one hold at E15, none after.
    task automatic test_long_press;
        logic [3:0] el, er, ef, eh;
        for (int rep = 0; rep < 2; rep++) begin
            button = IDLE | 4'b1000;
            for (int k = 0; k < 30; k++) begin
                tick(1);
                el = (k >= 5)  ? 4'b1000 : 4'b0000;
                er = (k == 5)  ? 4'b1000 : 4'b0000;
                eh = (k == 15) ? 4'b1000 : 4'b0000;
                checks++; if (level !== el) begin failures++;
                    $display("FAIL long_level r=%0d k=%0d got=%b exp=%b", rep, k, level, el); end
                checks++; if (rise !== er) begin failures++;
                    $display("FAIL long_rise r=%0d k=%0d got=%b exp=%b", rep, k, rise, er); end
                checks++; if (hold !== eh) begin failures++;
                    $display("FAIL long_hold r=%0d k=%0d got=%b exp=%b", rep, k, hold, eh); end
            end
            button = IDLE;
            for (int k = 0; k < 8; k++) begin
                tick(1);
                ef = (k == 5) ? 4'b1000 : 4'b0000;
                checks++; if (fall !== ef) begin failures++;
                    $display("FAIL long_fall r=%0d k=%0d got=%b exp=%b", rep, k, fall, ef); end
                checks++; if (hold !== 4'b0000) begin failures++;
                    $display("FAIL long_relhold r=%0d k=%0d got=%b exp=0000", rep, k, hold); end
            end
        end
    endtask

    // Release timed so the fall lands on the edge where hold would hit terminal.
    task automatic test_hold_vs_release;
        logic [3:0] ef;
        button = IDLE | 4'b1000;
        tick(10);
        checks++; if (level !== 4'b1000) begin failures++;
            $display("FAIL hvr_level got=%b exp=1000", level); end
        button = IDLE;
        for (int k = 10; k < 20; k++) begin
            tick(1);
            ef = (k == 15) ? 4'b1000 : 4'b0000;
            checks++; if (fall !== ef) begin failures++;
                $display("FAIL hvr_fall k=%0d got=%b exp=%b", k, fall, ef); end
            checks++; if (hold !== 4'b0000) begin failures++;
                $display("FAIL hvr_hold k=%0d got=%b exp=0000", k, hold); end
        end
    endtask

    // ch0 and ch1 pressed together, ch1 bounces so its last 0->1 is two cycles later.
    task automatic test_simultaneous;
        logic [3:0] el, er;
        for (int k = 0; k < 10; k++) begin
            button = IDLE | 4'b0001 | ((k == 1) ? 4'b0000 : 4'b0010);
            tick(1);
            el = ((k >= 5) ? 4'b0001 : 4'b0000) | ((k >= 7) ? 4'b0010 : 4'b0000);
            er = ((k == 5) ? 4'b0001 : 4'b0000) | ((k == 7) ? 4'b0010 : 4'b0000);
            checks++; if (level !== el) begin failures++;
                $display("FAIL sim_level k=%0d got=%b exp=%b", k, level, el); end
            checks++; if (rise !== er) begin failures++;
                $display("FAIL sim_rise k=%0d got=%b exp=%b", k, rise, er); end
            checks++; if ({fall, hold} !== 8'h0) begin failures++;
                $display("FAIL sim_fallhold k=%0d got=%b exp=00000000", k, {fall, hold}); end
        end
        button = IDLE;
        tick(8);
        checks++; if (level !== 4'b0000) begin failures++;
            $display("FAIL sim_release got=%b exp=0000", level); end
    endtask

    // ch3 high and ch0 mid-count when reset hits; both re-qualify from scratch.
    task automatic test_reset_mid;
        logic [3:0] el, er;
        button = IDLE | 4'b1000;
        tick(6);
        checks++; if (level !== 4'b1000) begin failures++;
            $display("FAIL rmid_pre got=%b exp=1000", level); end
        button = IDLE | 4'b1001;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++; if ({level, rise, fall, hold} !== 16'h0) begin failures++;
            $display("FAIL rmid_reset got=%h exp=0000", {level, rise, fall, hold}); end
        for (int k = 0; k < 7; k++) begin
            tick(1);
            el = (k >= 5) ? 4'b1001 : 4'b0000;
            er = (k == 5) ? 4'b1001 : 4'b0000;
            checks++; if (level !== el) begin failures++;
                $display("FAIL rmid_level k=%0d got=%b exp=%b", k, level, el); end
            checks++; if (rise !== er) begin failures++;
                $display("FAIL rmid_rise k=%0d got=%b exp=%b", k, rise, er); end
            checks++; if ({fall, hold} !== 8'h0) begin failures++;
                $display("FAIL rmid_fallhold k=%0d got=%b exp=00000000", k, {fall, hold}); end
        end
        button = IDLE;
        tick(8);
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_invert;
        test_long_press;
        test_hold_vs_release;
        test_simultaneous;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
